clint_ctrl: RTL and testbench

CLINT_CTRL -- requirements
Module: clint_ctrl

---
 rtl/clint_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_clint_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_ctrl.sv
// clint_ctrl: machine-mode trap/return sequencer for a single-hart core.
//
// Watches the ID/EX instruction for ECALL, EBREAK and MRET, and the timer interrupt
// request. On a trigger it stalls the pipeline, writes mepc/mcause/mstatus (trap) or
// mstatus (MRET) through a single CSR write port one register per cycle, and then
// issues a one-cycle PC redirect to mtvec (trap) or mepc (MRET).
//
// Ports:
//   clk, rst_n          clock; synchronous reset, asserted when rst_n = 1
//   inst_i              instruction currently in ID/EX
//   inst_addr_i         PC of inst_i
//   inst_valid_i        inst_i / inst_addr_i valid this cycle
//   int_flag_i          timer interrupt request (level)
//   jump_busy_i         an EX branch/jump is resolving this cycle
//   global_int_en_i     mstatus.MIE
//   csr_mtvec_i         live mtvec
//   csr_mepc_i          live mepc
//   csr_mstatus_i       live mstatus
//   csr_wb_we_i         WB stage owns the CSR write port this cycle
//   we_o/waddr_o/wdata_o  CSR write request
//   hold_flag_o         pipeline stall request
//   jump_flag_o         one-cycle PC redirect
//   jump_addr_o         redirect target

module clint_ctrl #(
   parameter int unsigned     XLEN       = 64,
   parameter logic [XLEN-1:0] MCAUSE_TMR = 64'h8000_0000_0000_0007
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] inst_addr_i,
   input  logic            inst_valid_i,
   input  logic            int_flag_i,
   input  logic            jump_busy_i,
   input  logic            global_int_en_i,
   input  logic [XLEN-1:0] csr_mtvec_i,
   input  logic [XLEN-1:0] csr_mepc_i,
   input  logic [XLEN-1:0] csr_mstatus_i,
   input  logic            csr_wb_we_i,
   output logic            we_o,
   output logic [XLEN-1:0] waddr_o,
   output logic [XLEN-1:0] wdata_o,
   output logic            hold_flag_o,
   output logic            jump_flag_o,
   output logic [XLEN-1:0] jump_addr_o
);

   localparam logic [31:0] InstEcall  = 32'h0000_0073;
   localparam logic [31:0] InstEbreak = 32'h0010_0073;
   localparam logic [31:0] InstMret   = 32'h3020_0073;

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMepc    = 12'h341;
   localparam logic [11:0] CsrMcause  = 12'h342;

   localparam logic [XLEN-1:0] CauseEcall  = XLEN'(11);
   localparam logic [XLEN-1:0] CauseEbreak = XLEN'(3);

   typedef enum logic [2:0] {
      StIdle,
      StWMepc,
      StWMcause,
      StWMstatus,
      StMMstatus,
      StJump
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic            mret_q, mret_d;

   logic            is_ecall, is_ebreak, is_mret, is_irq, trigger;
   logic [XLEN-1:0] mstatus_trap, mstatus_mret;

   // mtvec mode bits are dropped: only direct mode is supported.
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^csr_mtvec_i[1:0];

   // Exact-match decode; a near-miss encoding is simply not a trigger.
   always_comb begin
      is_ecall  = inst_valid_i && (inst_i == InstEcall);
      is_ebreak = inst_valid_i && (inst_i == InstEbreak);
      is_mret   = inst_valid_i && (inst_i == InstMret);
      // No interrupt while a branch resolves, so the saved PC is never a wrong-path PC.
      is_irq    = int_flag_i && global_int_en_i && inst_valid_i && !jump_busy_i;
      trigger   = is_ecall || is_ebreak || is_mret || is_irq;
   end

   // Trap entry: MPIE <= MIE, MIE <= 0. Return: MIE <= MPIE, MPIE <= 1.
   always_comb begin
      mstatus_trap    = csr_mstatus_i;
      mstatus_trap[7] = csr_mstatus_i[3];
      mstatus_trap[3] = 1'b0;
      mstatus_mret    = csr_mstatus_i;
      mstatus_mret[3] = csr_mstatus_i[7];
      mstatus_mret[7] = 1'b1;
   end

   // Next-state: write states advance only once the CSR port was not taken by WB.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      mret_d  = mret_q;
      unique case (state_q)
         StIdle: begin
            if (is_ecall || is_ebreak || is_mret) begin
               pc_d = inst_addr_i;
               if (is_mret) begin
                  state_d = StMMstatus;
                  mret_d  = 1'b1;
                  cause_d = '0;
               end else begin
                  state_d = StWMepc;
                  mret_d  = 1'b0;
                  cause_d = is_ecall ? CauseEcall : CauseEbreak;
               end
            end else if (is_irq) begin
               state_d = StWMepc;
               pc_d    = inst_addr_i;
               cause_d = MCAUSE_TMR;
               mret_d  = 1'b0;
            end
         end
         StWMepc: begin
            if (!csr_wb_we_i) state_d = StWMcause;
         end
         StWMcause: begin
            if (!csr_wb_we_i) state_d = StWMstatus;
         end
         StWMstatus: begin
            if (!csr_wb_we_i) state_d = StJump;
         end
         StMMstatus: begin
            if (!csr_wb_we_i) state_d = StJump;
         end
         StJump: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decode from the registered state; hold also covers the trigger cycle itself.
   always_comb begin
      we_o        = 1'b0;
      waddr_o     = '0;
      wdata_o     = '0;
      jump_flag_o = 1'b0;
      jump_addr_o = '0;
      hold_flag_o = (state_q != StIdle) || trigger;
      unique case (state_q)
         StWMepc: begin
            we_o    = 1'b1;
            waddr_o = XLEN'(CsrMepc);
            wdata_o = pc_q;
         end
         StWMcause: begin
            we_o    = 1'b1;
            waddr_o = XLEN'(CsrMcause);
            wdata_o = cause_q;
         end
         StWMstatus: begin
            we_o    = 1'b1;
            waddr_o = XLEN'(CsrMstatus);
            wdata_o = mstatus_trap;
         end
         StMMstatus: begin
            we_o    = 1'b1;
            waddr_o = XLEN'(CsrMstatus);
            wdata_o = mstatus_mret;
         end
         StJump: begin
            jump_flag_o = 1'b1;
            jump_addr_o = mret_q ? csr_mepc_i : {csr_mtvec_i[XLEN-1:2], 2'b00};
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= StIdle;
         pc_q    <= '0;
         cause_q <= '0;
         mret_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         mret_q  <= mret_d;
      end
   end

endmodule

// File: tb/tb_clint_ctrl.sv
// Bench for clint_ctrl: directed vectors, a queue-based behavioural model checked every
// cycle, and literal expectations on the logged CSR writes and jumps.

module tb_clint_ctrl;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [63:0] TMR    = 64'h8000_0000_0000_0007;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic [63:0] inst_addr;
   logic        inst_valid, int_flag, jump_busy, gie, wb_we;
   logic [63:0] mtvec, mepc, mstatus;
   logic        we_o, hold_o, jf_o;
   logic [63:0] waddr_o, wdata_o, ja_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int          c;
      logic [63:0] a;
      logic [63:0] d;
   } ev_t;
   ev_t  wlog[$];
   ev_t  jlog[$];
   logic hold_hist [0:4095];

   always #5 clk = ~clk;

   clint_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .inst_i          (inst),
      .inst_addr_i     (inst_addr),
      .inst_valid_i    (inst_valid),
      .int_flag_i      (int_flag),
      .jump_busy_i     (jump_busy),
      .global_int_en_i (gie),
      .csr_mtvec_i     (mtvec),
      .csr_mepc_i      (mepc),
      .csr_mstatus_i   (mstatus),
      .csr_wb_we_i     (wb_we),
      .we_o            (we_o),
      .waddr_o         (waddr_o),
      .wdata_o         (wdata_o),
      .hold_flag_o     (hold_o),
      .jump_flag_o     (jf_o),
      .jump_addr_o     (ja_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Model: when busy, a queue of pending CSR writes, then one jump cycle.
   bit          m_valid = 0;
   bit          m_busy  = 0;
   bit          m_mret  = 0;
   int          m_wq[$];
   logic [63:0] m_pc, m_cause;

   initial begin
      forever begin
         bit          ec, eb, mr, irq, trig;
         logic        e_we, e_jf, e_hold;
         logic [63:0] e_wa, e_wd, e_ja;
         @(negedge clk);
         ec   = inst_valid && inst == ECALL;
         eb   = inst_valid && inst == EBREAK;
         mr   = inst_valid && inst == MRET;
         irq  = int_flag && gie && inst_valid && !jump_busy;
         trig = ec || eb || mr || irq;
         e_we = 0; e_jf = 0; e_hold = 0; e_wa = 0; e_wd = 0; e_ja = 0;
         if (!m_busy) begin
            e_hold = trig;
         end else if (m_wq.size() > 0) begin
            e_hold = 1; e_we = 1;
            case (m_wq[0])
               0: begin e_wa = 64'h341; e_wd = m_pc; end
               1: begin e_wa = 64'h342; e_wd = m_cause; end
               2: begin
                  e_wa = 64'h300;
                  e_wd = (mstatus & ~64'h88) | (((mstatus >> 3) & 64'h1) << 7);
               end
               default: begin
                  e_wa = 64'h300;
                  e_wd = (mstatus & ~64'h8) | (((mstatus >> 7) & 64'h1) << 3) | 64'h80;
               end
            endcase
         end else begin
            e_hold = 1; e_jf = 1;
            e_ja   = m_mret ? mepc : (mtvec & ~64'h3);
         end
         if (m_valid) begin
            check("we_o", {63'd0, we_o}, {63'd0, e_we});
            check("waddr_o", waddr_o, e_wa);
            check("wdata_o", wdata_o, e_wd);
            check("hold_flag_o", {63'd0, hold_o}, {63'd0, e_hold});
            check("jump_flag_o", {63'd0, jf_o}, {63'd0, e_jf});
            check("jump_addr_o", ja_o, e_ja);
         end
         hold_hist[cyc] = hold_o;
         if (we_o === 1'b1) wlog.push_back('{c: cyc, a: waddr_o, d: wdata_o});
         if (jf_o === 1'b1) jlog.push_back('{c: cyc, a: ja_o, d: 64'd0});
         if (rst_n) begin
            m_busy = 0; m_wq.delete(); m_pc = 0; m_cause = 0; m_mret = 0; m_valid = 1;
         end else if (!m_busy) begin
            if (trig) begin
               m_busy = 1;
               m_pc   = inst_addr;
               if (mr) begin
                  m_mret = 1; m_wq = '{3};
               end else begin
                  m_mret  = 0; m_wq = '{0, 1, 2};
                  m_cause = ec ? 64'd11 : (eb ? 64'd3 : TMR);
               end
            end
         end else if (m_wq.size() > 0) begin
            if (!wb_we) void'(m_wq.pop_front());
         end else begin
            m_busy = 0;
         end
         cyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      inst = NOP; inst_valid = 0; inst_addr = 64'h0;
      int_flag = 0; jump_busy = 0; wb_we = 0;
   endtask

   task automatic clear_logs();
      wlog.delete();
      jlog.delete();
   endtask

   task automatic fire(input logic [31:0] i, input logic [63:0] pc, output int t);
      inst = i; inst_valid = 1; inst_addr = pc; t = cyc;
   endtask

   task automatic check_write(input string name, input int c, input logic [63:0] a,
                              input logic [63:0] d);
      logic [63:0] fa, fd;
      fa = 64'hDEAD_DEAD_DEAD_DEAD;
      fd = 64'hDEAD_DEAD_DEAD_DEAD;
      foreach (wlog[k]) if (wlog[k].c == c) begin fa = wlog[k].a; fd = wlog[k].d; end
      check({name, "_addr"}, fa, a);
      check({name, "_data"}, fd, d);
   endtask

   task automatic check_jump(input string name, input int c, input logic [63:0] a);
      check({name, "_count"}, 64'(jlog.size()), 64'd1);
      if (jlog.size() > 0) begin
         check({name, "_cycle"}, 64'(jlog[0].c), 64'(c));
         check({name, "_addr"}, jlog[0].a, a);
      end
   endtask

   initial begin
      int t;
      idle_in();
      gie = 1; mtvec = 64'h8000_0100; mepc = 64'h0; mstatus = 64'h8;
      rst_n = 1;
      repeat (3) step();
      rst_n = 0;
      check("reset_we", {63'd0, we_o}, 64'd0);
      check("reset_hold", {63'd0, hold_o}, 64'd0);
      check("reset_jump", {63'd0, jf_o}, 64'd0);
      check("reset_waddr", waddr_o, 64'd0);
      step();

      // ECALL trap sequence
      clear_logs();
      fire(ECALL, 64'h8000_0010, t);
      step(); idle_in();
      repeat (7) step();
      check("ecall_nwrites", 64'(wlog.size()), 64'd3);
      check_write("ecall_mepc", t + 1, 64'h341, 64'h8000_0010);
      check_write("ecall_mcause", t + 2, 64'h342, 64'd11);
      check_write("ecall_mstatus", t + 3, 64'h300, 64'h80);
      check_jump("ecall_jump", t + 4, 64'h8000_0100);
      for (int c = 0; c <= 4; c++) check("ecall_hold", {63'd0, hold_hist[t + c]}, 64'd1);
      check("ecall_hold_end", {63'd0, hold_hist[t + 5]}, 64'd0);

      // MRET
      clear_logs();
      mstatus = 64'h80; mepc = 64'h8000_0014;
      fire(MRET, 64'h8000_0040, t);
      step(); idle_in();
      repeat (5) step();
      check("mret_nwrites", 64'(wlog.size()), 64'd1);
      check_write("mret_mstatus", t + 1, 64'h300, 64'h88);
      check_jump("mret_jump", t + 2, 64'h8000_0014);

      // EBREAK with other mstatus bits set and mtvec mode bits set
      clear_logs();
      mstatus = 64'h1808; mtvec = 64'h8000_0103;
      fire(EBREAK, 64'h8000_0030, t);
      step(); idle_in();
      repeat (7) step();
      check_write("ebreak_mcause", t + 2, 64'h342, 64'd3);
      check_write("ebreak_mstatus", t + 3, 64'h300, 64'h1880);
      check_jump("ebreak_jump", t + 4, 64'h8000_0100);

      // Timer interrupt
      clear_logs();
      mstatus = 64'h8; mtvec = 64'h8000_0100;
      fire(NOP, 64'h8000_0020, t); int_flag = 1;
      step(); idle_in();
      repeat (7) step();
      check_write("irq_mepc", t + 1, 64'h341, 64'h8000_0020);
      check_write("irq_mcause", t + 2, 64'h342, TMR);
      check_jump("irq_jump", t + 4, 64'h8000_0100);

      // Interrupt masked by MIE, then blocked by a resolving jump
      clear_logs();
      fire(NOP, 64'h8000_0020, t); int_flag = 1; gie = 0;
      repeat (3) step();
      gie = 1; jump_busy = 1;
      repeat (3) step();
      idle_in();
      repeat (3) step();
      check("masked_nwrites", 64'(wlog.size()), 64'd0);
      check("masked_njumps", 64'(jlog.size()), 64'd0);
      check("masked_hold", {63'd0, hold_hist[t]}, 64'd0);
      check("busy_hold", {63'd0, hold_hist[t + 4]}, 64'd0);

      // WB owns the write port for two cycles during W_MCAUSE
      clear_logs();
      fire(ECALL, 64'h8000_0050, t);
      step(); idle_in();
      step(); wb_we = 1;
      step();
      step(); wb_we = 0;
      repeat (6) step();
      check("retry_nwrites", 64'(wlog.size()), 64'd5);
      check_write("retry_mcause0", t + 2, 64'h342, 64'd11);
      check_write("retry_mcause1", t + 3, 64'h342, 64'd11);
      check_write("retry_mcause2", t + 4, 64'h342, 64'd11);
      check_write("retry_mstatus", t + 5, 64'h300, 64'h80);
      check_jump("retry_jump", t + 6, 64'h8000_0100);

      // Reset while in W_MCAUSE
      clear_logs();
      fire(ECALL, 64'h8000_0060, t);
      step(); idle_in();
      step(); rst_n = 1;
      step(); rst_n = 0;
      check("midreset_we", {63'd0, we_o}, 64'd0);
      check("midreset_hold", {63'd0, hold_o}, 64'd0);
      repeat (6) step();
      check("midreset_nwrites", 64'(wlog.size()), 64'd2);
      check("midreset_njumps", 64'(jlog.size()), 64'd0);

      // ECALL and interrupt together: ECALL wins
      clear_logs();
      fire(ECALL, 64'h8000_0070, t); int_flag = 1;
      step(); idle_in();
      repeat (7) step();
      check_write("both_mcause", t + 2, 64'h342, 64'd11);

      // Triggers while busy are ignored
      clear_logs();
      fire(ECALL, 64'h8000_0080, t);
      step(); inst = EBREAK; inst_addr = 64'h8000_0084;
      step(); inst = MRET;
      step(); idle_in();
      repeat (6) step();
      check("busy_nwrites", 64'(wlog.size()), 64'd3);
      check_write("busy_mepc", t + 1, 64'h341, 64'h8000_0080);
      check_write("busy_mcause", t + 2, 64'h342, 64'd11);

      // Near-miss encodings and invalid instructions do nothing
      clear_logs();
      inst = MRET; inst_valid = 0; inst_addr = 64'h8000_0090;
      step();
      inst = 32'h0020_0073; inst_valid = 1;
      step(); idle_in();
      repeat (4) step();
      check("nearmiss_nwrites", 64'(wlog.size()), 64'd0);
      check("nearmiss_njumps", 64'(jlog.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
